// File: rtl/mem_wb_stage_v2_pkg.sv
// mem_wb_stage_v2_pkg: shared widths and write-back / load-size encodings for the MEM/WB stage
package mem_wb_stage_v2_pkg;
    localparam int ADDRWIDTH = 7;
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC  = 2'b10;
    localparam logic [1:0] WB_SEL_INM = 2'b11;
    localparam logic [1:0] LD_BYTE    = 2'b00;
    localparam logic [1:0] LD_HALF    = 2'b01;
    localparam logic [1:0] LD_WORD    = 2'b10;
endpackage

// File: rtl/mem_wb_stage_v2_load_extender.sv
// load_extender: picks a little-endian byte/half lane of a memory word and sign/zero-extends it
module load_extender
    import mem_wb_stage_v2_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] data,
    input  logic [1:0]         size,
    input  logic               is_unsigned,
    input  logic [1:0]         addr,
    output logic [NB_DATA-1:0] ext
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    assign byte_sel = data[{addr, 3'b000} +: 8];
    assign half_sel = data[{addr[1], 4'b0000} +: 16];
    always_comb begin
        ext = size == LD_BYTE ? {{(NB_DATA-8){~is_unsigned & byte_sel[7]}}, byte_sel}
            : size == LD_HALF ? {{(NB_DATA-16){~is_unsigned & half_sel[15]}}, half_sel}
            : data;
    end
endmodule

// File: rtl/mem_wb_stage_v2.sv
// mem_wb_stage_v2: MEM/WB register with valid/flush/stall, WB mux, sticky halt, retire counter.
// Define LOAD_EXT_EN to enable sub-word load extraction.
module mem_wb_stage_v2
    import mem_wb_stage_v2_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int NB_REG    = 5,
    parameter int NB_PC     = ADDRWIDTH,
    parameter int NB_RETIRE = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 enable_pipe_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic                 halt_detected_i,
    input  logic [NB_DATA-1:0]   mem_data_read_i,
    input  logic [NB_DATA-1:0]   alu_result_i,
    input  logic [NB_DATA-1:0]   data_inm_i,
    input  logic [NB_PC-1:0]     pc_i,
    input  logic [NB_REG-1:0]    write_register_i,
    input  logic [2:0]           wb_signals_i,
    input  logic [1:0]           load_size_i,
    input  logic                 load_unsigned_i,
    output logic [NB_REG-1:0]    write_register_o,
    output logic                 reg_write_o,
    output logic [NB_DATA-1:0]   wb_data_o,
    output logic                 valid_o,
    output logic                 halt_detected_o,
    output logic [NB_RETIRE-1:0] retired_count_o
);
    logic [NB_REG-1:0]    write_register_q;
    logic                 reg_write_q;
    logic [1:0]           mem_to_reg_q;
    logic [NB_DATA-1:0]   mem_data_q;
    logic [NB_DATA-1:0]   alu_q;
    logic [NB_DATA-1:0]   inm_q;
    logic [NB_PC-1:0]     pc_q;
    logic                 valid_q;
    logic                 halt_q;
    logic [NB_RETIRE-1:0] count_q;
    logic [NB_DATA-1:0]   load_data;
`ifdef LOAD_EXT_EN
    logic [1:0]           load_size_q;
    logic                 load_unsigned_q;
`endif

    // Halt freezes everything; flush only drops the valid bit and wins over stall and halt capture
    always_ff @(negedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            write_register_q <= '0;
            reg_write_q      <= 1'b0;
            mem_to_reg_q     <= WB_SEL_ALU;
            mem_data_q       <= '0;
            alu_q            <= '0;
            inm_q            <= '0;
            pc_q             <= '0;
            valid_q          <= 1'b0;
            halt_q           <= 1'b0;
            count_q          <= '0;
`ifdef LOAD_EXT_EN
            load_size_q      <= LD_BYTE;
            load_unsigned_q  <= 1'b0;
`endif
        end else if (!halt_q) begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (enable_pipe_i) begin
                write_register_q <= write_register_i;
                reg_write_q      <= wb_signals_i[2];
                mem_to_reg_q     <= wb_signals_i[1:0];
                mem_data_q       <= mem_data_read_i;
                alu_q            <= alu_result_i;
                inm_q            <= data_inm_i;
                pc_q             <= pc_i;
                valid_q          <= valid_i;
                halt_q           <= halt_detected_i & valid_i;
`ifdef LOAD_EXT_EN
                load_size_q      <= load_size_i;
                load_unsigned_q  <= load_unsigned_i;
`endif
                if (valid_i && !(&count_q))
                    count_q <= count_q + 1'b1;
            end
        end
    end

`ifdef LOAD_EXT_EN
    load_extender #(.NB_DATA(NB_DATA)) u_load_extender (
        .data        (mem_data_q),
        .size        (load_size_q),
        .is_unsigned (load_unsigned_q),
        .addr        (alu_q[1:0]),
        .ext         (load_data)
    );
`else
    logic unused_load_ctrl;
    assign unused_load_ctrl = ^{load_size_i, load_unsigned_i};
    assign load_data = mem_data_q;
`endif

    always_comb begin
        wb_data_o = mem_to_reg_q == WB_SEL_ALU ? alu_q
                  : mem_to_reg_q == WB_SEL_MEM ? load_data
                  : mem_to_reg_q == WB_SEL_PC  ? {{(NB_DATA-NB_PC){1'b0}}, pc_q}
                  : inm_q;
    end

    assign write_register_o = write_register_q;
    assign reg_write_o      = reg_write_q & valid_q;
    assign valid_o          = valid_q;
    assign halt_detected_o  = halt_q;
    assign retired_count_o  = count_q;
endmodule

// File: tb/tb_mem_wb_stage_v2.sv
// tb_mem_wb_stage_v2: directed scoreboard bench for mem_wb_stage_v2 (default and LOAD_EXT_EN builds)
module tb_mem_wb_stage_v2;
    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_pipe_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        halt_detected_i = 1'b0;
    logic [31:0] mem_data_read_i = 32'h80FF7F01;
    logic [31:0] alu_result_i = '0;
    logic [31:0] data_inm_i = 32'hABCD0000;
    logic [6:0]  pc_i = 7'h44;
    logic [4:0]  write_register_i = '0;
    logic [2:0]  wb_signals_i = '0;
    logic [1:0]  load_size_i = 2'b10;
    logic        load_unsigned_i = 1'b0;
    logic [4:0]  write_register_o, s_write_register_o;
    logic        reg_write_o, s_reg_write_o;
    logic [31:0] wb_data_o, s_wb_data_o;
    logic        valid_o, s_valid_o;
    logic        halt_detected_o, s_halt_detected_o;
    logic [15:0] retired_count_o;
    logic [3:0]  s_retired_count_o;

    typedef struct {
        logic [4:0]  wr;
        logic        rw;
        logic [31:0] data;
        logic        v;
        logic        h;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

`ifdef LOAD_EXT_EN
    localparam logic [31:0] LD_B3S = 32'hFFFFFF80;
    localparam logic [31:0] LD_H2U = 32'h000080FF;
    localparam logic [31:0] LD_B1S = 32'h0000007F;
`else
    localparam logic [31:0] LD_B3S = 32'h80FF7F01;
    localparam logic [31:0] LD_H2U = 32'h80FF7F01;
    localparam logic [31:0] LD_B1S = 32'h80FF7F01;
`endif

    mem_wb_stage_v2 dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_pipe_i(enable_pipe_i), .flush_i(flush_i),
        .valid_i(valid_i), .halt_detected_i(halt_detected_i), .mem_data_read_i(mem_data_read_i),
        .alu_result_i(alu_result_i), .data_inm_i(data_inm_i), .pc_i(pc_i),
        .write_register_i(write_register_i), .wb_signals_i(wb_signals_i), .load_size_i(load_size_i),
        .load_unsigned_i(load_unsigned_i), .write_register_o(write_register_o), .reg_write_o(reg_write_o),
        .wb_data_o(wb_data_o), .valid_o(valid_o), .halt_detected_o(halt_detected_o),
        .retired_count_o(retired_count_o)
    );

    mem_wb_stage_v2 #(.NB_RETIRE(4)) dut_small (
        .clock_i(clock_i), .reset_i(reset_i), .enable_pipe_i(enable_pipe_i), .flush_i(flush_i),
        .valid_i(valid_i), .halt_detected_i(halt_detected_i), .mem_data_read_i(mem_data_read_i),
        .alu_result_i(alu_result_i), .data_inm_i(data_inm_i), .pc_i(pc_i),
        .write_register_i(write_register_i), .wb_signals_i(wb_signals_i), .load_size_i(load_size_i),
        .load_unsigned_i(load_unsigned_i), .write_register_o(s_write_register_o), .reg_write_o(s_reg_write_o),
        .wb_data_o(s_wb_data_o), .valid_o(s_valid_o), .halt_detected_o(s_halt_detected_o),
        .retired_count_o(s_retired_count_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Capture happens on the falling edge, so outputs are sampled on the rising edge
    always @(posedge clock_i) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("write_register", 32'(write_register_o), 32'(e.wr));
            chk("reg_write", 32'(reg_write_o), 32'(e.rw));
            chk("wb_data", wb_data_o, e.data);
            chk("valid", 32'(valid_o), 32'(e.v));
            chk("halt", 32'(halt_detected_o), 32'(e.h));
            chk("retired_count", 32'(retired_count_o), 32'(e.cnt));
            chk("retired_count_sat4", 32'(s_retired_count_o), e.cnt > 16'd15 ? 32'hF : 32'(e.cnt));
        end
    end

    task automatic cyc(input logic rst, input logic en, input logic fl, input logic v, input logic h,
                       input logic [2:0] wb, input logic [31:0] alu, input logic [4:0] wr,
                       input logic [1:0] ls, input logic lu);
        @(posedge clock_i);
        #1;
        reset_i = rst; enable_pipe_i = en; flush_i = fl; valid_i = v; halt_detected_i = h;
        wb_signals_i = wb; alu_result_i = alu; write_register_i = wr;
        load_size_i = ls; load_unsigned_i = lu;
    endtask

    task automatic ex(input logic [4:0] wr, input logic rw, input logic [31:0] data,
                      input logic v, input logic h, input logic [15:0] cnt);
        q.push_back('{wr, rw, data, v, h, cnt});
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 3'b000, 32'h0, 5'd0, 2'b10, 0);            ex(0, 0, 32'h0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 3'b100, 32'h1234, 5'd5, 2'b10, 0);         ex(5, 1, 32'h1234, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 3'b111, 32'h9990 + i, 5'd9, 2'b10, 0); ex(5, 1, 32'h1234, 1, 0, 1);
        end
        cyc(0, 0, 1, 1, 0, 3'b100, 32'h4444, 5'd9, 2'b10, 0);         ex(5, 0, 32'h1234, 0, 0, 1);
        cyc(0, 1, 0, 1, 0, 3'b110, 32'h0, 5'd31, 2'b10, 0);           ex(31, 1, 32'h44, 1, 0, 2);
        cyc(0, 1, 0, 1, 0, 3'b111, 32'h0, 5'd2, 2'b10, 0);            ex(2, 1, 32'hABCD0000, 1, 0, 3);
        cyc(0, 1, 0, 1, 0, 3'b001, 32'h3, 5'd3, 2'b00, 0);            ex(3, 0, LD_B3S, 1, 0, 4);
        cyc(0, 1, 0, 1, 0, 3'b101, 32'h2, 5'd4, 2'b01, 1);            ex(4, 1, LD_H2U, 1, 0, 5);
        cyc(0, 1, 0, 1, 0, 3'b101, 32'h1, 5'd6, 2'b00, 0);            ex(6, 1, LD_B1S, 1, 0, 6);
        cyc(0, 1, 0, 1, 0, 3'b101, 32'h1, 5'd6, 2'b10, 0);            ex(6, 1, 32'h80FF7F01, 1, 0, 7);
        cyc(0, 1, 0, 0, 1, 3'b100, 32'h55, 5'd7, 2'b10, 0);           ex(7, 0, 32'h55, 0, 0, 7);
        cyc(0, 1, 1, 1, 1, 3'b100, 32'h66, 5'd8, 2'b10, 0);           ex(7, 0, 32'h55, 0, 0, 7);
        cyc(0, 1, 0, 1, 1, 3'b100, 32'h77, 5'd10, 2'b10, 0);          ex(10, 1, 32'h77, 1, 1, 8);
        cyc(0, 1, 0, 1, 0, 3'b110, 32'h88, 5'd11, 2'b10, 0);          ex(10, 1, 32'h77, 1, 1, 8);
        cyc(0, 1, 0, 1, 0, 3'b100, 32'h99, 5'd12, 2'b10, 0);          ex(10, 1, 32'h77, 1, 1, 8);
        // Short reset pulse between edges: only an asynchronous reset can clear the frozen halt
        cyc(0, 1, 0, 0, 0, 3'b000, 32'h0, 5'd0, 2'b10, 0);
        reset_i = 1'b1;
        #1;
        chk("async_clear_halt", 32'(halt_detected_o), 32'h0);
        chk("async_clear_valid", 32'(valid_o), 32'h0);
        chk("async_clear_data", wb_data_o, 32'h0);
        #1;
        reset_i = 1'b0;
        ex(0, 0, 32'h0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            cyc(0, 1, 0, 1, 0, 3'b100, 32'(i), 5'd1, 2'b10, 0);       ex(1, 1, 32'(i), 1, 0, 16'(i));
        end
        cyc(0, 1, 0, 1, 0, 3'b100, 32'h5A, 5'd1, 2'b10, 0);           ex(1, 1, 32'h5A, 1, 0, 18);
        repeat (3) @(posedge clock_i);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
